seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- 8-bit multi-cycle universal shifter: one 1-bit shift step per clock, repeated shift_amt times.
- Supports logical left, logical right, arithmetic right and rotate right.
- Small datapath utility for the simple processor's ALU/shift path, with a start/done handshake.
- Datapath (shift-step mux, counter decrement, zero detect) built from gate-level primitives; state registers are plain flip-flops.

Parameters:
- None. Data width fixed at 8, shift-amount width fixed at 3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- ctrl  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- shift_amt  input  3  number of 1-bit steps, 0..7.
- data_in  input  8  operand, captured when start is accepted.
- data_out  output  8  working/result register, driven directly from the register.
- done  output  1  high when the result is valid; level, not a pulse.

Behaviour:
- Reset (async, rst=1): state=IDLE, data_out=0, internal count=0, latched ctrl=00, done=0. rst overrides everything, including mid-operation; the operation is abandoned.
- States: IDLE, SHIFT, DONE.
- Start acceptance, IDLE or DONE with start=1 at the rising edge:
  - data_out <= data_in; count <= shift_amt; op <= ctrl.
  - done <= 0; next state SHIFT.
- SHIFT, count != 0: apply one step to data_out; count <= count-1.
  - LSL: {d[6:0],0}
  - LSR: {0,d[7:1]}
  - ASR: {d[7],d[7:1]}
  - ROR: {d[0],d[7:1]}
- SHIFT, count == 0: no shift; done <= 1; next state DONE.
- DONE: hold data_out and done=1 until a new start is accepted. Without a new start, stay in DONE indefinitely.
- Latency:
  - done rises on the (shift_amt+2)-th rising edge counting the accepting edge as edge 1.
  - shift_amt=0: data_out = data_in, done after 2 edges.
- start while in SHIFT: ignored; inputs not re-latched.
- ctrl, shift_amt and data_in may change freely after acceptance. Only the latched copies are used.
- data_out shows intermediate values during SHIFT. It is valid only while done=1.
- No overflow/carry outputs; bits shifted out are discarded, except under ROR.

Test Plan:
- Reset: assert rst for 2 cycles -> data_out=00000000, done=0. Assert rst mid-SHIFT -> immediate return to these values, state IDLE.
- LSL by 1, data_in=10110011, ctrl=00 -> done=1, data_out=01100110 after 3 edges.
- LSR by 2, data_in=10110011, ctrl=01 -> data_out=00101100. Back-to-back start issued from DONE is accepted.
- ASR by 3, data_in=10110011, ctrl=10 -> data_out=11110110. Also data_in=01110000 gives 00001110.
- ROR by 4, data_in=10110011, ctrl=11 -> data_out=00111011. ROR by 7 of 00000001 -> 00000010.
- Edge cases:
  - shift_amt=0 -> data_out=data_in, done after 2 edges.
  - start pulsed during SHIFT -> ignored, result unchanged.
  - Inputs changed after acceptance -> no effect on the result.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle 8-bit universal shifter (LSL/LSR/ASR/ROR), one bit per clock,
// with a start/done handshake. Step mux, decrement and zero detect are gate-level.
module seq_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ctrl,
  input  logic [2:0] shift_amt,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       done_q, done_d;

  logic [7:0] step_s;
  logic [2:0] dec_s;
  logic       cnt_zero_s;
  logic       is_lsl_s, is_right_s, nop0_s;
  logic       ror_bit_s, asr_bit_s, right_fill_sel_s, fill_s, lsl7_s;
  logic [6:1] lsl_mid_s, rsh_mid_s;

  // One-step shift mux: LSL takes the lower neighbour, right shifts the upper one.
  nor g_is_lsl (is_lsl_s, op_q[1], op_q[0]);
  not g_is_right (is_right_s, is_lsl_s);
  and g_bit0 (step_s[0], is_right_s, data_q[1]);

  for (genvar i = 1; i < 7; i++) begin : g_mid
    and g_l (lsl_mid_s[i], is_lsl_s, data_q[i-1]);
    and g_r (rsh_mid_s[i], is_right_s, data_q[i+1]);
    or  g_o (step_s[i], lsl_mid_s[i], rsh_mid_s[i]);
  end

  // MSB fill: LSR -> 0, ASR -> old MSB, ROR -> old LSB.
  not g_nop0 (nop0_s, op_q[0]);
  and g_ror7 (ror_bit_s, op_q[0], data_q[0]);
  and g_asr7 (asr_bit_s, nop0_s, data_q[7]);
  or  g_sel7 (right_fill_sel_s, ror_bit_s, asr_bit_s);
  and g_fill7 (fill_s, op_q[1], right_fill_sel_s);
  and g_lsl7 (lsl7_s, is_lsl_s, data_q[6]);
  or  g_bit7 (step_s[7], lsl7_s, fill_s);

  not  g_dec0 (dec_s[0], cnt_q[0]);
  xnor g_dec1 (dec_s[1], cnt_q[1], cnt_q[0]);
  logic borrow2_s;
  nor  g_brw2 (borrow2_s, cnt_q[1], cnt_q[0]);
  xor  g_dec2 (dec_s[2], cnt_q[2], borrow2_s);
  nor  g_zero (cnt_zero_s, cnt_q[2], cnt_q[1], cnt_q[0]);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_d  = data_in;
          cnt_d   = shift_amt;
          op_d    = ctrl;
          done_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero_s) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          data_d = step_s;
          cnt_d  = dec_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: arithmetic reference model checked every
// cycle, plus literal result and latency expectations.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [2:0] shift_amt = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shifter dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl),
    .shift_amt(shift_amt), .data_in(data_in),
    .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] op,
                                           input logic [2:0] n);
    logic signed [7:0] sd;
    logic [15:0] dd;
    sd = d;
    dd = {d, d};
    case (op)
      2'b00:   ref_shift = d << n;
      2'b01:   ref_shift = d >> n;
      2'b10:   ref_shift = sd >>> n;
      default: ref_shift = 8'(dd >> n);
    endcase
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: result computed at acceptance, done after shift_amt+1 further edges.
  logic [7:0] m_result;
  logic [3:0] m_left;
  logic       m_busy, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_result <= 8'h00;
      m_left   <= 4'd0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 4'd1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      m_left <= m_left - 4'd1;
    end else if (start) begin
      m_result <= ref_shift(data_in, ctrl, shift_amt);
      m_left   <= {1'b0, shift_amt} + 4'd1;
      m_busy   <= 1'b1;
      m_done   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check8("reset_data", data_out, 8'h00);
      check8("reset_done", {7'd0, done}, 8'd0);
    end else begin
      check8("model_done", {7'd0, done}, {7'd0, m_done});
      if (m_done) check8("model_data", data_out, m_result);
    end
  end

  task automatic run_op(input string name, input logic [7:0] d, input logic [1:0] op,
                        input logic [2:0] n, input logic [7:0] exp, input bit glitch);
    int edges;
    @(negedge clk);
    data_in = d; ctrl = op; shift_amt = n; start = 1'b1;
    @(negedge clk);
    edges = 1;
    start = 1'b0;
    data_in = ~d; ctrl = ~op; shift_amt = ~n;
    while (!done && edges < 20) begin
      if (glitch && edges == 2) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check8({name, "_latency"}, 8'(edges), 8'(n) + 8'd2);
    check8({name, "_result"}, data_out, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check8("rst_hold_data", data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    run_op("lsl1",  8'b10110011, 2'b00, 3'd1, 8'b01100110, 1'b0);
    run_op("lsr2",  8'b10110011, 2'b01, 3'd2, 8'b00101100, 1'b0);
    run_op("asr3a", 8'b10110011, 2'b10, 3'd3, 8'b11110110, 1'b0);
    run_op("asr3b", 8'b01110000, 2'b10, 3'd3, 8'b00001110, 1'b0);
    run_op("ror4",  8'b10110011, 2'b11, 3'd4, 8'b00111011, 1'b0);
    run_op("ror7",  8'b00000001, 2'b11, 3'd7, 8'b00000010, 1'b0);
    run_op("amt0",  8'b10100101, 2'b01, 3'd0, 8'b10100101, 1'b0);
    run_op("glitch_lsl5", 8'b10110011, 2'b00, 3'd5, 8'b01100000, 1'b1);
    run_op("ror3",  8'b11000001, 2'b11, 3'd3, 8'b00111000, 1'b0);
    run_op("lsr7",  8'b10000000, 2'b01, 3'd7, 8'b00000001, 1'b0);

    // Hold in DONE without a new start.
    repeat (3) @(negedge clk);
    check8("done_hold_data", data_out, 8'b00000001);
    check8("done_hold_flag", {7'd0, done}, 8'd1);

    // Reset in the middle of a shift.
    @(negedge clk);
    data_in = 8'b10110011; ctrl = 2'b11; shift_amt = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check8("midrst_data", data_out, 8'h00);
    check8("midrst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check8("idle_after_rst", {7'd0, done}, 8'd0);

    run_op("post_rst_asr1", 8'b10000010, 2'b10, 3'd1, 8'b11000001, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
